// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: access-size encodings, access-unit FSM states,
// the latched request payload and small size/alignment helpers.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  // Same encoding the store/load extenders use.
  typedef enum logic [1:0] {
    SIZE_WORD     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_BYTE     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } mau_state_e;

  // Fields of an accepted request still needed after the bus cycle is launched.
  typedef struct packed {
    logic      we;
    mem_size_e size;
    logic [1:0] addr_lo;
  } mem_req_t;

  function automatic mem_size_e size_norm(input logic [1:0] size);
    return (size == SIZE_WORD_ALT) ? SIZE_WORD : mem_size_e'(size);
  endfunction

  function automatic logic [1:0] force_align(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return lo;
      SIZE_HALF: return {lo[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      default:   return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the right-justified MEM-stage view and the
// word-wide little-endian bus: byte enables, store shift, load shift/zero.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_lane
);

  logic [DATA_W-1:0] rdata_shift;

  assign rdata_shift = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_lane = rdata;
    case (size_norm(size))
      SIZE_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = wdata << {addr_lo[1], 4'b0000};
        rdata_lane = rdata_shift & 32'h0000_FFFF;
      end
      SIZE_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = wdata << {addr_lo, 3'b000};
        rdata_lane = rdata_shift & 32'h0000_00FF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage bus access unit: accepts one load/store, runs a single bus cycle
// with ack timeout, and returns a one-cycle completion pulse.
// Optional build macro MEM_ALIGN_CHECK_EN: fault misaligned half/word accesses
// instead of silently aligning them.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_req,
  input  logic        Mem_we,
  input  logic [1:0]  Mem_size,
  input  logic [31:0] Mem_addr,
  input  logic [31:0] Mem_datain,
  output logic        Mem_stall,
  output logic        Mem_done,
  output logic [31:0] Mem_Do,
  output logic        Mem_err,
  output logic        Mem_misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned    CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mau_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;

  logic              bus_req_d, bus_we_d;
  logic [31:0]       bus_addr_d, bus_wdata_d;
  logic [3:0]        bus_be_d;
  logic              done_d, err_d, misalign_d;
  logic [31:0]       do_d;

  mem_size_e         idle_size;
  logic [1:0]        idle_lo;
  logic              misalign_c;
  logic [1:0]        lane_size;
  logic [1:0]        lane_lo;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, lane_rdata;

  // Alignment policy applied to the incoming request before lane steering.
  always_comb begin
    idle_size = size_norm(Mem_size);
`ifdef MEM_ALIGN_CHECK_EN
    idle_lo    = Mem_addr[1:0];
    misalign_c = is_misaligned(idle_size, Mem_addr[1:0]);
`else
    idle_lo    = force_align(idle_size, Mem_addr[1:0]);
    misalign_c = 1'b0;
`endif
  end

  // Live request steers lanes while idle; the latched request does afterwards.
  assign lane_size = (state_q == ST_IDLE) ? idle_size : req_q.size;
  assign lane_lo   = (state_q == ST_IDLE) ? idle_lo   : req_q.addr_lo;

  mem_lane_align u_lane (
    .size       (lane_size),
    .addr_lo    (lane_lo),
    .wdata      (Mem_datain),
    .rdata      (bus_rdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_lane (lane_rdata)
  );

  assign Mem_stall = ((state_q == ST_IDLE) && Mem_req) || (state_q == ST_BUS);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_be_d    = bus_be;
    bus_wdata_d = bus_wdata;
    done_d      = 1'b0;
    err_d       = 1'b0;
    misalign_d  = 1'b0;
    do_d        = Mem_Do;

    case (state_q)
      ST_IDLE: begin
        if (Mem_req) begin
          req_d = '{we: Mem_we, size: idle_size, addr_lo: idle_lo};
          if (misalign_c) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
            do_d       = '0;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = Mem_we;
            bus_addr_d  = {Mem_addr[31:2], 2'b00};
            bus_be_d    = lane_be;
            bus_wdata_d = lane_wdata;
          end
        end
      end
      ST_BUS: begin
        // Ack wins over a timeout landing in the same cycle.
        if (bus_ack) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          do_d      = req_q.we ? '0 : lane_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          do_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      req_q        <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      Mem_done     <= 1'b0;
      Mem_err      <= 1'b0;
      Mem_misalign <= 1'b0;
      Mem_Do       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      bus_req      <= bus_req_d;
      bus_we       <= bus_we_d;
      bus_addr     <= bus_addr_d;
      bus_be       <= bus_be_d;
      bus_wdata    <= bus_wdata_d;
      Mem_done     <= done_d;
      Mem_err      <= err_d;
      Mem_misalign <= misalign_d;
      Mem_Do       <= do_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit against a byte-arithmetic
// reference model; honours MEM_ALIGN_CHECK_EN when it is defined.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_req, Mem_we;
  logic [1:0]  Mem_size;
  logic [31:0] Mem_addr, Mem_datain;
  logic        Mem_stall, Mem_done, Mem_err, Mem_misalign;
  logic [31:0] Mem_Do;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .Mem_req      (Mem_req),
    .Mem_we       (Mem_we),
    .Mem_size     (Mem_size),
    .Mem_addr     (Mem_addr),
    .Mem_datain   (Mem_datain),
    .Mem_stall    (Mem_stall),
    .Mem_done     (Mem_done),
    .Mem_Do       (Mem_Do),
    .Mem_err      (Mem_err),
    .Mem_misalign (Mem_misalign),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] s);
    case (s)
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access; the bus responder acks ack_dly cycles after bus_req
  // first rises, or never when ack_dly >= TO.
  task automatic txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] data, input int ack_dly, input logic [31:0] rdata);
    int          nb, off, nbus;
    logic        misal, timeout;
    logic [3:0]  exp_be;
    logic [63:0] w64, mask;
    logic [31:0] exp_wd, exp_do;

    nb  = nbytes_of(size);
    off = int'(addr % 4);
    off = off - (off % nb);
    misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = (addr % nb) != 0;
`endif
    exp_be  = 4'(((1 << nb) - 1) << off);
    w64     = {32'd0, data} << (8 * off);
    exp_wd  = w64[31:0];
    mask    = (64'd1 << (8 * nb)) - 64'd1;
    w64     = ({32'd0, rdata} >> (8 * off)) & mask;
    timeout = ack_dly >= TO;
    exp_do  = (we || timeout || misal) ? 32'd0 : w64[31:0];
    nbus    = timeout ? TO : ack_dly + 1;

    Mem_req = 1'b1; Mem_we = we; Mem_size = size; Mem_addr = addr; Mem_datain = data;
    #1;
    check("stall_idle_req", 32'(Mem_stall), 32'd1);
    tick();
    // Scramble the request inputs: the latched copy must be used from here on.
    Mem_req = 1'b0; Mem_we = ~we; Mem_size = 2'($urandom);
    Mem_addr = $urandom; Mem_datain = $urandom;

    if (!misal) begin
      for (int k = 0; k < nbus; k++) begin
        check("bus_req", 32'(bus_req), 32'd1);
        check("bus_addr", bus_addr, addr & ~32'd3);
        check("bus_be", 32'(bus_be), 32'(exp_be));
        check("bus_we", 32'(bus_we), 32'(we));
        if (we) check("bus_wdata", bus_wdata, exp_wd);
        check("stall_bus", 32'(Mem_stall), 32'd1);
        check("done_early", 32'(Mem_done), 32'd0);
        bus_ack   = (k == ack_dly);
        bus_rdata = (k == ack_dly) ? rdata : $urandom;
        tick();
        bus_ack = 1'b0;
      end
    end

    check("done", 32'(Mem_done), 32'd1);
    check("err", 32'(Mem_err), 32'(timeout && !misal));
    check("misalign", 32'(Mem_misalign), 32'(misal));
    check("do", Mem_Do, exp_do);
    check("bus_req_done", 32'(bus_req), 32'd0);
    // A request and a stray ack during DONE must both be ignored.
    Mem_req = 1'b1; bus_ack = 1'b1; bus_rdata = $urandom;
    #1;
    check("stall_done", 32'(Mem_stall), 32'd0);
    tick();
    Mem_req = 1'b0; bus_ack = 1'b0;
    #1;
    check("done_pulse", 32'(Mem_done), 32'd0);
    check("idle_bus_req", 32'(bus_req), 32'd0);
    check("idle_stall", 32'(Mem_stall), 32'd0);
    check("idle_do_hold", Mem_Do, exp_do);
  endtask

  initial begin
    rst = 1'b1; Mem_req = 1'b0; Mem_we = 1'b0; Mem_size = 2'b00;
    Mem_addr = '0; Mem_datain = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_done", 32'(Mem_done), 32'd0);
    check("rst_err", 32'(Mem_err), 32'd0);
    check("rst_misalign", 32'(Mem_misalign), 32'd0);
    check("rst_do", Mem_Do, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_stall", 32'(Mem_stall), 32'd0);
    rst = 1'b0;
    tick();

    // Byte store to the top lane, ack two cycles after bus_req rises.
    txn(1'b1, 2'b10, 32'h0000_1003, 32'h0000_00AB, 2, 32'h0);
    // Half load from the upper half.
    txn(1'b0, 2'b01, 32'h0000_2002, 32'h0, 0, 32'h8765_4321);
    // Word load that never sees an ack.
    txn(1'b0, 2'b00, 32'h0000_4000, 32'h0, 100, 32'h0);
    // Ack arriving on the timeout cycle completes normally.
    txn(1'b0, 2'b00, 32'h0000_5000, 32'h0, TO - 1, 32'hCAFE_F00D);
    // Misaligned word load.
    txn(1'b0, 2'b00, 32'h0000_3001, 32'h0, 0, 32'h1234_5678);
    // Size 11 behaves as word; misaligned half store.
    txn(1'b1, 2'b11, 32'h0000_6004, 32'hDEAD_BEEF, 1, 32'h0);
    txn(1'b1, 2'b01, 32'h0000_7003, 32'h0000_BEEF, 0, 32'h0);
    txn(1'b0, 2'b10, 32'h0000_8001, 32'h0, 3, 32'hA1B2_C3D4);

    // Reset on the second BUS cycle, together with an ack.
    Mem_req = 1'b1; Mem_we = 1'b1; Mem_size = 2'b00;
    Mem_addr = 32'h0000_9000; Mem_datain = 32'h1111_2222;
    tick();
    Mem_req = 1'b0;
    check("rst_mid_bus_req1", 32'(bus_req), 32'd1);
    tick();
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    rst = 1'b0; bus_ack = 1'b0;
    check("rst_mid_bus_req", 32'(bus_req), 32'd0);
    check("rst_mid_done", 32'(Mem_done), 32'd0);
    check("rst_mid_do", Mem_Do, 32'd0);
    check("rst_mid_be", 32'(bus_be), 32'd0);
    check("rst_mid_wdata", bus_wdata, 32'd0);
    check("rst_mid_addr", bus_addr, 32'd0);
    check("rst_mid_we", 32'(bus_we), 32'd0);
    // New request in the first cycle after reset falls.
    txn(1'b0, 2'b10, 32'h0000_A002, 32'h0, 1, 32'h0F0E_0D0C);

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), 2'($urandom), $urandom, $urandom,
          int'($urandom_range(0, TO + 1)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
